// File: rtl/pipe_write_back.sv
// pipe_write_back: Y86-64 write-back stage with integrated register file
//   Optional macro WB_BYPASS_EN: read ports forward the value committing this cycle.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     w_valid               W stage holds an instruction
//     w_icode, w_rA, w_rB   instruction fields used to derive dstE/dstM
//     w_cnd                 execute condition (cmovXX)
//     w_valE, w_valM        ALU result, memory read data
//     w_stat                1 AOK, 2 HLT, 3 ADR, 4 INS
//     rd_a_addr/rd_a_data   combinational read port A
//     rd_b_addr/rd_b_data   combinational read port B
//     halted, stat_out      sticky halt flag and latched final status
//     retired               count of committed AOK instructions
module pipe_write_back #(
    parameter int DATA_W   = 64,
    parameter int NREGS    = 15,
    parameter int RSP_ADDR = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_valid,
    input  logic [3:0]        w_icode,
    input  logic [3:0]        w_rA,
    input  logic [3:0]        w_rB,
    input  logic              w_cnd,
    input  logic [DATA_W-1:0] w_valE,
    input  logic [DATA_W-1:0] w_valM,
    input  logic [2:0]        w_stat,
    input  logic [3:0]        rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [3:0]        rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              halted,
    output logic [2:0]        stat_out,
    output logic [CNT_W-1:0]  retired
);
    localparam logic       RUN  = 1'b0;
    localparam logic       HALT = 1'b1;
    localparam logic [3:0] NONE = 4'hF;
    localparam logic [3:0] RSP  = RSP_ADDR[3:0];
    localparam logic [4:0] NR   = NREGS[4:0];

    logic              state;
    logic [DATA_W-1:0] regs [16];
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic              accept;
    logic              commit;
    logic              we_e;
    logic              we_m;

    // NREGS never exceeds 15, so the "none" code 4'hF is always out of range too
    function automatic logic ok(input logic [3:0] a);
        return {1'b0, a} < NR;
    endfunction

    always_comb begin
        dst_e  = (w_icode == 4'h2) ? (w_cnd ? w_rB : NONE) :
                 (w_icode == 4'h3 || w_icode == 4'h6) ? w_rB :
                 (w_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : NONE;
        dst_m  = (w_icode == 4'h5 || w_icode == 4'hB) ? w_rA : NONE;
        accept = w_valid && state == RUN;
        commit = accept && w_stat == 3'd1;
        we_m   = commit && ok(dst_m);
        // popq %rsp: the M write shadows the E write to the same register
        we_e   = commit && ok(dst_e) && dst_e != dst_m;
    end

    always_comb begin
        rd_a_data = ok(rd_a_addr) ? regs[rd_a_addr] : '0;
        rd_b_data = ok(rd_b_addr) ? regs[rd_b_addr] : '0;
`ifdef WB_BYPASS_EN
        if (we_e && rd_a_addr == dst_e) rd_a_data = w_valE;
        if (we_m && rd_a_addr == dst_m) rd_a_data = w_valM;
        if (we_e && rd_b_addr == dst_e) rd_b_data = w_valE;
        if (we_m && rd_b_addr == dst_m) rd_b_data = w_valM;
`endif
    end

    // Entries at or above NREGS are never written and stay constant zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            state    <= RUN;
            stat_out <= 3'd1;
            retired  <= '0;
        end else begin
            if (we_e) regs[dst_e] <= w_valE;
            if (we_m) regs[dst_m] <= w_valM;
            if (commit) retired <= retired + 1'b1;
            if (accept && w_stat != 3'd1) begin
                state    <= HALT;
                stat_out <= w_stat;
            end
        end
    end

    assign halted = state == HALT;
endmodule

// File: tb/tb_pipe_write_back.sv
// tb_pipe_write_back: randomized check of pipe_write_back against a behavioural register-file model
module tb_pipe_write_back;
    localparam int NREGS = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_valid;
    logic [3:0]  w_icode;
    logic [3:0]  w_rA;
    logic [3:0]  w_rB;
    logic        w_cnd;
    logic [63:0] w_valE;
    logic [63:0] w_valM;
    logic [2:0]  w_stat;
    logic [3:0]  rd_a_addr;
    logic [63:0] rd_a_data;
    logic [3:0]  rd_b_addr;
    logic [63:0] rd_b_data;
    logic        halted;
    logic [2:0]  stat_out;
    logic [31:0] retired;

    pipe_write_back dut (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_icode(w_icode), .w_rA(w_rA),
        .w_rB(w_rB), .w_cnd(w_cnd), .w_valE(w_valE), .w_valM(w_valM), .w_stat(w_stat),
        .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data), .rd_b_addr(rd_b_addr),
        .rd_b_data(rd_b_data), .halted(halted), .stat_out(stat_out), .retired(retired)
    );

    always #10 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [63:0] m_regs [16];
    logic [63:0] nxt [16];
    logic        m_halted;
    logic [2:0]  m_stat;
    logic [31:0] m_ret;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
        case (ic)
            4'h2:                   return c ? rb : 4'hF;
            4'h3, 4'h6:             return rb;
            4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
        return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
    endfunction

    // register contents after the coming edge; M is applied last so it wins
    task automatic model_next();
        logic [3:0] de, dm;
        nxt = m_regs;
        de = m_dst_e(w_icode, w_rB, w_cnd);
        dm = m_dst_m(w_icode, w_rA);
        if (w_valid && !m_halted && w_stat == 3'd1) begin
            if (int'(de) < NREGS) nxt[de] = w_valE;
            if (int'(dm) < NREGS) nxt[dm] = w_valM;
        end
    endtask

    task automatic cycle(input logic v, input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic c, input logic [63:0] ve, input logic [63:0] vm, input logic [2:0] st,
                         input logic [3:0] aa, input logic [3:0] ab);
        w_valid = v; w_icode = ic; w_rA = ra; w_rB = rb; w_cnd = c;
        w_valE = ve; w_valM = vm; w_stat = st; rd_a_addr = aa; rd_b_addr = ab;
        model_next();
        #1;
`ifdef WB_BYPASS_EN
        check("rd_a", rd_a_data, nxt[aa]);
        check("rd_b", rd_b_data, nxt[ab]);
`else
        check("rd_a", rd_a_data, m_regs[aa]);
        check("rd_b", rd_b_data, m_regs[ab]);
`endif
        @(posedge clk);
        if (v && !m_halted) begin
            if (st == 3'd1) m_ret++;
            else begin
                m_halted = 1'b1;
                m_stat = st;
            end
        end
        m_regs = nxt;
        #1;
        check("halted", {63'd0, halted}, {63'd0, m_halted});
        check("stat_out", {61'd0, stat_out}, {61'd0, m_stat});
        check("retired", {32'd0, retired}, {32'd0, m_ret});
    endtask

    // rst rises between edges; everything must clear before the next edge
    task automatic do_reset();
        #3;
        rst = 1'b1;
        w_valid = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_halted = 1'b0;
        m_stat = 3'd1;
        m_ret = '0;
        #1;
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_stat", {61'd0, stat_out}, 64'd1);
        check("rst_retired", {32'd0, retired}, 64'd0);
        for (int a = 0; a < 8; a++) begin
            rd_a_addr = 4'(a);
            rd_b_addr = 4'(15 - a);
            #1;
            check("rst_rd_a", rd_a_data, 64'd0);
            check("rst_rd_b", rd_b_data, 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        w_valid = 1'b0; w_icode = '0; w_rA = '0; w_rB = '0; w_cnd = 1'b0;
        w_valE = '0; w_valM = '0; w_stat = 3'd1; rd_a_addr = '0; rd_b_addr = '0;
        do_reset();

        cycle(1, 4'h3, 4'hF, 4'h1, 0, 64'd20, 64'd0, 3'd1, 4'h1, 4'h2);
        cycle(1, 4'h2, 4'h0, 4'h2, 0, 64'd99, 64'd0, 3'd1, 4'h1, 4'h2);
        check("irmovq_r1", rd_a_data, 64'd20);
        check("cmov_r2", rd_b_data, 64'd0);
        check("retired_2", {32'd0, retired}, 64'd2);

        cycle(1, 4'hB, 4'h4, 4'hF, 0, 64'h108, 64'h55, 3'd1, 4'h4, 4'h4);
        cycle(0, 4'h0, 4'hF, 4'hF, 0, 64'd0, 64'd0, 3'd1, 4'h4, 4'h3);
        check("popq_rsp", rd_a_data, 64'h55);

        cycle(1, 4'h5, 4'h3, 4'hF, 0, 64'd0, 64'd10, 3'd1, 4'h1, 4'h3);
        cycle(0, 4'h0, 4'hF, 4'hF, 0, 64'd0, 64'd0, 3'd1, 4'h1, 4'h3);
        check("mrmovq_r3", rd_b_data, 64'd10);

        cycle(1, 4'h3, 4'hF, 4'h5, 0, 64'd77, 64'd0, 3'd3, 4'h5, 4'h4);
        cycle(1, 4'h3, 4'hF, 4'h5, 0, 64'd88, 64'd0, 3'd1, 4'h5, 4'h4);
        check("halt_flag", {63'd0, halted}, 64'd1);
        check("halt_stat", {61'd0, stat_out}, 64'd3);
        check("halt_r5", rd_a_data, 64'd0);
        check("halt_retired", {32'd0, retired}, 64'd4);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            logic [2:0] st;
            st = ($urandom_range(0, 79) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            cycle($urandom_range(0, 4) != 0, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, st, 4'($urandom), 4'($urandom));
            if (m_halted && $urandom_range(0, 9) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
